inst_loader: RTL
================

# inst_loader

Boot-time program loader that drives the write side of the byte-addressed, big-endian instruction memory. It accepts a program image as a byte stream (valid/ready) and assembles each group of four bytes into a 32-bit word, first byte into bits [31:24]. It writes each word to consecutive word addresses through the memory's Address/RW/DataIn port, then pulses Done so the CPU can be released from hold. It sits between the board-level byte source (UART/ROM reader) and the instruction memory, muxed in front of the PC fetch path while Busy is high.

## Interface
Parameters:
- BASE_ADDR, 0: byte address of the first word written; must be a multiple of 4.
- MAX_WORDS, 15: capacity in words (61-byte memory holds 15 full words).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST_n  in  1  reset, asynchronous, active-low.
- Start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- Length  in  8  number of words to load; sampled with Start.
- ByteIn  in  8  next image byte.
- ByteValid  in  1  ByteIn is valid.
- ByteReady  out  1  loader accepts a byte this cycle.
- MemAddress  out  32  to memory Address.
- MemRW  out  1  to memory RW; 1 = read, 0 = write.
- MemDataOut  out  32  to memory DataIn.
- MemDataIn  in  32  from memory DataOut (used only with verify).
- Busy  out  1  load in progress.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  sticky fault flag; cleared by the next accepted Start.
- WordsWritten  out  8  count of words committed in the current/last load.

## Operation
- States: IDLE, COLLECT, WRITE, CHECK (verify builds only), DONE.
- IDLE:
  - Start=1 with Length=0 -> DONE, no memory writes.
  - Start=1 with Length>MAX_WORDS -> Error=1, DONE, no writes.
  - Otherwise latch Length, set MemAddress=BASE_ADDR, clear Error and WordsWritten, go to COLLECT.
- COLLECT:
  - ByteReady=1.
  - Each handshake (ByteValid&ByteReady at posedge) shifts ByteIn into the word register: byte k of 0..3 lands at bits [31-8k:24-8k].
  - ByteValid low stalls indefinitely; the partial word is held.
  - After the 4th byte -> WRITE.
- WRITE:
  - MemRW=0 for exactly one cycle; MemAddress and MemDataOut are stable for the whole cycle, so the memory captures on that cycle's negedge.
  - WordsWritten increments at the end of WRITE.
  - Next state is CHECK (verify builds) or the advance step.
- Advance:
  - If WordsWritten equals Length -> DONE.
  - Otherwise MemAddress += 4 -> COLLECT.
- DONE: Done=1 and Busy=0 for one cycle -> IDLE.
- Start in any state other than IDLE is ignored.
- MemDataOut holds the last written word. MemAddress holds its last value in IDLE.
- Address arithmetic is 32-bit unsigned; no wrap is possible within MAX_WORDS.

## Timing
- Reset values: ByteReady=0, MemAddress=BASE_ADDR, MemRW=1, MemDataOut=0, Busy=0, Done=0, Error=0, WordsWritten=0; state IDLE.
- Start accepted at edge 0 -> Busy=1 and ByteReady=1 from cycle 1.
- With ByteValid held high, a word costs 4 COLLECT cycles plus 1 WRITE cycle (plus 1 CHECK cycle with verify).
- Done asserts in the cycle after the last WRITE (or CHECK). Total for N words with no stalls: 5N+1 cycles from Start to Done, or 6N+1 with verify.
- MemRW is registered; it is never 0 outside WRITE.
- RST_n assertion mid-load forces MemRW=1 immediately. A WRITE cycle hit by reset before its negedge writes nothing. The partial word is discarded and Done is not pulsed.

## Configuration
- LOADER_VERIFY_EN defined:
  - CHECK state present. After each WRITE, one cycle with MemRW=1 at the same address; MemDataIn is compared to the word register at the end of the cycle.
  - On mismatch: Error=1, the load aborts to DONE, and WordsWritten keeps the count including the failing word.
- LOADER_VERIFY_EN undefined:
  - No CHECK state; MemDataIn is unused.
  - Error is set only by the Length range check.

## Test plan
- Reset, then idle 5 cycles -> MemRW=1, Busy=0, Done=0, MemAddress=0, ByteReady=0.
- Start, Length=2, bytes 12 34 56 78 9A BC DE F0 streamed continuously -> exactly two MemRW=0 cycles: first Address 0 / Data 0x12345678, then Address 4 / Data 0x9ABCDEF0. Done pulses on cycle 11 (13 with verify). Memory readback at 0 and 4 matches. WordsWritten=2.
- ByteValid deasserted for 7 cycles after the 2nd byte -> no write during the stall; word 0x11223344 written once the remaining bytes arrive; no bytes lost or duplicated.
- Start with Length=0 -> Done next cycle, no writes, Error=0. Start with Length=16 -> Done, Error=1, no writes. A following valid Start clears Error.
- RST_n pulsed low during the WRITE cycle of word 1 before its negedge -> memory at address 4 unchanged, all outputs at reset values, no Done.
- Verify build: memory model forced to corrupt bit 0 of the word at address 0 -> Error=1 after the CHECK cycle, Done pulses, WordsWritten=1, no write to address 4.

Source files
------------

// File: rtl/inst_loader.sv
// Boot-time loader: packs a big-endian byte stream into 32-bit words and writes them to instruction memory.
// Optional read-back verify of every written word is enabled by defining LOADER_VERIFY_EN.
//
// state   | meaning
// IDLE    | waiting for Start; MemAddress holds its last value
// COLLECT | accepting image bytes into the word register
// WRITE   | one MemRW=0 cycle with address and data stable
// CHECK   | read back the word just written (LOADER_VERIFY_EN only)
// DONE    | one-cycle completion pulse, Busy low
module inst_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 15
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        Start,
  input  logic [7:0]  Length,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic [31:0] MemAddress,
  output logic        MemRW,
  output logic [31:0] MemDataOut,
  input  logic [31:0] MemDataIn,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [7:0]  WordsWritten
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
`ifdef LOADER_VERIFY_EN
  localparam logic [2:0] S_CHECK   = 3'd3;
`endif
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [7:0] LP_MAX_WORDS = 8'(MAX_WORDS);

  logic [2:0]  r_state;
  logic [7:0]  r_length;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_shift;
  logic [31:0] r_data_out;
  logic [31:0] r_addr;
  logic        r_mem_rw;
  logic        r_error;
  logic [7:0]  r_words;

  logic        w_hs;
  logic [7:0]  w_words_inc;

  assign w_hs        = (r_state == S_COLLECT) && ByteValid;
  assign w_words_inc = r_words + 8'd1;

`ifndef LOADER_VERIFY_EN
  logic w_unused_mem_data;
  assign w_unused_mem_data = ^MemDataIn;
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state    <= S_IDLE;
      r_length   <= 8'd0;
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
      r_data_out <= 32'd0;
      r_addr     <= BASE_ADDR;
      r_mem_rw   <= 1'b1;
      r_error    <= 1'b0;
      r_words    <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (Length == 8'd0) begin
              r_error <= 1'b0;
              r_words <= 8'd0;
              r_state <= S_DONE;
            end else if (Length > LP_MAX_WORDS) begin
              r_error <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_length   <= Length;
              r_addr     <= BASE_ADDR;
              r_error    <= 1'b0;
              r_words    <= 8'd0;
              r_byte_cnt <= 2'd0;
              r_state    <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (w_hs) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            // First byte of the word ends up in [31:24] after four shifts.
            if (r_byte_cnt == 2'd3) begin
              r_data_out <= {r_shift, ByteIn};
              r_mem_rw   <= 1'b0;
              r_state    <= S_WRITE;
            end else begin
              r_shift <= {r_shift[15:0], ByteIn};
            end
          end
        end
        S_WRITE: begin
          r_mem_rw <= 1'b1;
          r_words  <= w_words_inc;
`ifdef LOADER_VERIFY_EN
          r_state  <= S_CHECK;
`else
          if (w_words_inc == r_length) begin
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_addr + 32'd4;
            r_state <= S_COLLECT;
          end
`endif
        end
`ifdef LOADER_VERIFY_EN
        S_CHECK: begin
          if (MemDataIn != r_data_out) begin
            r_error <= 1'b1;
            r_state <= S_DONE;
          end else if (r_words == r_length) begin
            r_state <= S_DONE;
          end else begin
            r_addr  <= r_addr + 32'd4;
            r_state <= S_COLLECT;
          end
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ByteReady    = (r_state == S_COLLECT);
  assign Busy         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign Done         = (r_state == S_DONE);
  assign MemAddress   = r_addr;
  assign MemRW        = r_mem_rw;
  assign MemDataOut   = r_data_out;
  assign Error        = r_error;
  assign WordsWritten = r_words;

endmodule
